my_rst_seq_ctrl: RTL and testbench
==================================

MY_RST_SEQ_CTRL -- requirements
Module: my_rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOM, default 4: number of reset/clock domains sequenced.
REQ-002 Parameter CNT_W, default 8: width of each per-domain release delay.
REQ-003 Parameter HOLD_CYC, default 4: cycles all domains are held in reset on a software reset.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port sw_rst_req, input, 1: single-cycle software reset request.
REQ-007 Port cfg_dly, input, NUM_DOM*CNT_W: release delay per domain; domain i uses bits [i*CNT_W +: CNT_W].
REQ-008 Port clk_en_req, input, NUM_DOM: requested clock enable per domain when running.
REQ-009 Port dom_rst_n, output, NUM_DOM: active-low reset per domain.
REQ-010 Port dom_clk_en, output, NUM_DOM: clock enable per domain.
REQ-011 Port busy, output, 1: high whenever the state is not RUN.
REQ-012 Port done, output, 1: one-cycle pulse when the release sequence completes.

Function
REQ-013 The FSM SHALL have states RST_SYNC, WAIT, SW_HOLD and RUN, plus a domain index idx of width clog2(NUM_DOM).
REQ-014 In RST_SYNC the block SHALL move to WAIT with idx=0 on the first edge where the synchronized reset is high.
REQ-015 On every entry to WAIT, the down-counter SHALL load cfg_dly[idx], sampled at that edge; later cfg_dly changes are ignored for that domain.
REQ-016 In WAIT with counter>0, the counter SHALL decrement by 1 per cycle.
REQ-017 In WAIT with counter==0, the next edge SHALL set dom_rst_n[idx]=1; if idx<NUM_DOM-1 it SHALL increment idx and re-enter WAIT, otherwise it SHALL enter RUN.
REQ-018 Consecutive domain releases SHALL be exactly cfg_dly[i]+1 cycles apart; a delay of 0 SHALL give a 1-cycle gap.
REQ-019 done SHALL be high only in the cycle in which dom_rst_n[NUM_DOM-1] first reads 1, for each completed sequence.
REQ-020 dom_clk_en[i] SHALL be 1 from WAIT entry for domain i until RUN, so the domain is clocked through its reset release.
REQ-021 In RUN, dom_clk_en SHALL equal clk_en_req registered once (1-cycle latency).
REQ-022 dom_clk_en[i] SHALL be 0 for any domain whose WAIT has not yet been entered.
REQ-023 sw_rst_req=1 in WAIT or RUN SHALL, at the next edge, drive all dom_rst_n to 0 and all dom_clk_en to 1, load the counter with HOLD_CYC-1 and enter SW_HOLD.
REQ-024 An sw_rst_req arriving mid-sequence SHALL abort the sequence, with no done pulse.
REQ-025 In SW_HOLD the counter SHALL decrement to 0; at counter==0 the block SHALL enter WAIT with idx=0.
REQ-026 sw_rst_req SHALL be ignored in RST_SYNC and SW_HOLD.
REQ-027 Already-released domains SHALL stay released until rst_n or a software reset is applied.

Reset
REQ-028 rst_n low SHALL immediately (asynchronously) set dom_rst_n=0, dom_clk_en=0, busy=1, done=0, state=RST_SYNC, idx=0 and counter=0.
REQ-029 rst_n deassertion SHALL be synchronized by a 2-flop synchronizer, so WAIT is entered 2 edges after rst_n rises.
REQ-030 rst_n asserted in any state, mid-sequence included, SHALL restart from RST_SYNC.

Structure
REQ-031 The state enum and default parameter constants SHALL live in the shared package my_rst_seq_pkg.
REQ-032 The 2-flop reset synchronizer SHALL be a separate sub-module named my_rst_sync.

Verification
REQ-033 Power-on test: NUM_DOM=4, cfg_dly={d0=3,d1=0,d2=5,d3=1}, edges counted from rst_n rising. Required: dom_rst_n bits rise at edges 6, 7, 13 and 15; done is high in cycle 15 only; busy falls at 15.
REQ-034 RUN test: in RUN, toggle clk_en_req=4'b1010 at edge t. Required: dom_clk_en=4'b1010 at t+1.
REQ-035 Software reset in RUN: pulse sw_rst_req at edge t. Required: all dom_rst_n=0 and dom_clk_en=4'hF at t+1; WAIT is entered at t+1+HOLD_CYC; the sequence then repeats with the power-on gaps.
REQ-036 Abort test: pulse sw_rst_req while domain 2 is waiting. Required: domains 0 and 1 return to reset; done is not pulsed; the full sequence restarts after the hold.
REQ-037 Async reset test: assert rst_n mid-WAIT between edges. Required: outputs reach their reset values without a clock edge; the sequence restarts after 2-edge synchronization.
REQ-038 All-zero delay test: cfg_dly=0, NUM_DOM=4. Required: releases at edges 3, 4, 5 and 6; done is high at edge 6.

Source files
------------

// File: rtl/my_rst_seq_pkg.sv
// Shared types and default sizing for the reset sequencer.
// Both the interface and the controller import this package.
package my_rst_seq_pkg;

    localparam int DEF_NUM_DOM  = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_HOLD_CYC = 4;

    typedef enum logic [1:0] {
        RST_SYNC = 2'd0,
        WAIT     = 2'd1,
        SW_HOLD  = 2'd2,
        RUN      = 2'd3
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/my_rst_seq_ctrl_if.sv
// Control/status bundle between a system controller and the reset sequencer.
// The controller (master) drives requests; the sequencer (slave) drives per-domain resets/enables.
interface my_rst_seq_ctrl_if
    import my_rst_seq_pkg::*;
#(
    parameter int NUM_DOM = DEF_NUM_DOM,
    parameter int CNT_W   = DEF_CNT_W
) ();

    logic                       sw_rst_req;
    logic [NUM_DOM*CNT_W-1:0]   cfg_dly;
    logic [NUM_DOM-1:0]         clk_en_req;
    logic [NUM_DOM-1:0]         dom_rst_n;
    logic [NUM_DOM-1:0]         dom_clk_en;
    logic                       busy;
    logic                       done;

    modport master (
        output sw_rst_req, cfg_dly, clk_en_req,
        input  dom_rst_n, dom_clk_en, busy, done
    );

    modport slave (
        input  sw_rst_req, cfg_dly, clk_en_req,
        output dom_rst_n, dom_clk_en, busy, done
    );

endinterface

// File: rtl/my_rst_sync.sv
// Two-flop synchronizer for the deassertion of the asynchronous reset.
// Exposes both stages so the sequencer can act on the edge the release reaches stage two.
module my_rst_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_arm,
    output logic rst_n_sync
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_arm  = sync_q[0];
    assign rst_n_sync = sync_q[1];

endmodule

// File: rtl/my_rst_seq_ctrl.sv
// Releases NUM_DOM reset domains one after another with programmable gaps,
// keeping each domain clocked through its release; supports a software reset with a hold time.
module my_rst_seq_ctrl
    import my_rst_seq_pkg::*;
#(
    parameter int NUM_DOM  = DEF_NUM_DOM,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    my_rst_seq_ctrl_if.slave bus
);

    localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
    localparam int CTR_W = max_int(CNT_W, $clog2(HOLD_CYC + 1));
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DOM - 1);
    localparam logic [CTR_W-1:0]   HOLD_LD  = CTR_W'(HOLD_CYC - 1);
    localparam logic [NUM_DOM-1:0] FIRST_EN = NUM_DOM'(1);

    seq_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_inc;
    logic [CTR_W-1:0]    cnt_q, cnt_d;
    logic [NUM_DOM-1:0]  dom_rst_n_q, dom_rst_n_d;
    logic [NUM_DOM-1:0]  dom_clk_en_q, dom_clk_en_d;
    logic                done_q, done_d;
    logic                rst_n_arm, rst_n_sync;
    logic                sw_take;
    logic [CTR_W-1:0]    dly_arr [NUM_DOM];

    my_rst_sync u_rst_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_n_arm  (rst_n_arm),
        .rst_n_sync (rst_n_sync)
    );

    for (genvar gi = 0; gi < NUM_DOM; gi++) begin : g_dly
        assign dly_arr[gi] = CTR_W'(bus.cfg_dly[gi*CNT_W +: CNT_W]);
    end

    assign idx_inc = idx_q + IDX_W'(1);
    assign sw_take = bus.sw_rst_req && ((state_q == WAIT) || (state_q == RUN));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        dom_rst_n_d  = dom_rst_n_q;
        dom_clk_en_d = dom_clk_en_q;
        done_d       = 1'b0;

        case (state_q)
            RST_SYNC: begin
                // Leave on the edge where the release lands in the second sync stage.
                if (rst_n_arm && !rst_n_sync) begin
                    state_d      = WAIT;
                    idx_d        = '0;
                    cnt_d        = dly_arr[0];
                    dom_clk_en_d = FIRST_EN;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CTR_W'(1);
                end else begin
                    dom_rst_n_d[idx_q] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d      = RUN;
                        done_d       = 1'b1;
                        dom_clk_en_d = bus.clk_en_req;
                    end else begin
                        idx_d                 = idx_inc;
                        cnt_d                 = dly_arr[idx_inc];
                        dom_clk_en_d[idx_inc] = 1'b1;
                    end
                end
            end
            SW_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CTR_W'(1);
                end else begin
                    state_d      = WAIT;
                    idx_d        = '0;
                    cnt_d        = dly_arr[0];
                    dom_clk_en_d = FIRST_EN;
                    dom_rst_n_d  = '0;
                end
            end
            RUN: begin
                dom_clk_en_d = bus.clk_en_req;
            end
            default: begin
                state_d = RST_SYNC;
            end
        endcase

        // A software reset overrides any release or enable update in the same cycle.
        if (sw_take) begin
            state_d      = SW_HOLD;
            idx_d        = '0;
            cnt_d        = HOLD_LD;
            dom_rst_n_d  = '0;
            dom_clk_en_d = '1;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RST_SYNC;
            idx_q        <= '0;
            cnt_q        <= '0;
            dom_rst_n_q  <= '0;
            dom_clk_en_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            dom_rst_n_q  <= dom_rst_n_d;
            dom_clk_en_q <= dom_clk_en_d;
            done_q       <= done_d;
        end
    end

    assign bus.dom_rst_n  = dom_rst_n_q;
    assign bus.dom_clk_en = dom_clk_en_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != RUN);

endmodule

// File: tb/tb_my_rst_seq_ctrl.sv
// Self-checking bench for my_rst_seq_ctrl: timeline tables feed a cycle-stamped
// scoreboard that a negedge monitor drains and compares.
module tb_my_rst_seq_ctrl;

    localparam logic [31:0] CFG_A = {8'd1, 8'd5, 8'd0, 8'd3};

    typedef struct {
        int         edge_no;
        logic [3:0] rst_exp;
        logic [3:0] en_exp;
        logic       busy_exp;
        logic       done_exp;
    } vec_t;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] rst_exp;
        logic [3:0] en_exp;
        logic       busy_exp;
        logic       done_exp;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    int   done_seen;
    sb_t  sb_q[$];
    vec_t pon_tab[10];
    vec_t zero_tab[7];

    my_rst_seq_ctrl_if #(.NUM_DOM(4), .CNT_W(8)) bus ();

    my_rst_seq_ctrl #(.NUM_DOM(4), .CNT_W(8), .HOLD_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare every entry due in the current cycle.
    always @(negedge clk) begin
        sb_t e;
        if (bus.done === 1'b1) done_seen++;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_chk++;
            if (e.cyc != cyc || bus.dom_rst_n !== e.rst_exp || bus.dom_clk_en !== e.en_exp ||
                bus.busy !== e.busy_exp || bus.done !== e.done_exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d (due %0d): got rst=%b en=%b busy=%b done=%b, want rst=%b en=%b busy=%b done=%b",
                         e.name, cyc, e.cyc, bus.dom_rst_n, bus.dom_clk_en, bus.busy, bus.done,
                         e.rst_exp, e.en_exp, e.busy_exp, e.done_exp);
            end else begin
                $display("chk %s cyc %0d rst=%b en=%b busy=%b done=%b ok",
                         e.name, cyc, bus.dom_rst_n, bus.dom_clk_en, bus.busy, bus.done);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input string nm, input logic [3:0] r, input logic [3:0] e,
                        input logic b, input logic d);
        sb_t s;
        s.cyc = c; s.name = nm; s.rst_exp = r; s.en_exp = e; s.busy_exp = b; s.done_exp = d;
        sb_q.push_back(s);
    endtask

    task automatic push_tab(input int base, input bit zero, input int lo, input int hi, input string tag);
        vec_t v;
        int   n;
        n = zero ? 7 : 10;
        for (int i = 0; i < n; i++) begin
            v = zero ? zero_tab[i] : pon_tab[i];
            if (v.edge_no >= lo && v.edge_no <= hi)
                push(base + v.edge_no, $sformatf("%s_e%0d", tag, v.edge_no),
                     v.rst_exp, v.en_exp, v.busy_exp, v.done_exp);
        end
    endtask

    task automatic push_hold(input int first, input string tag);
        for (int k = 0; k < 4; k++)
            push(first + k, $sformatf("%s_hold%0d", tag, k), 4'h0, 4'hF, 1'b1, 1'b0);
    endtask

    task automatic wait_drain(input int budget, input string tag);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: %0d entries still pending, want 0", tag, sb_q.size());
            sb_q.delete();
        end
        step();
    endtask

    initial begin
        int base;
        int t;

        // Timeline for cfg {d0=3,d1=0,d2=5,d3=1}, edges counted from rst_n release.
        pon_tab[0] = '{1,  4'h0, 4'h0, 1'b1, 1'b0};
        pon_tab[1] = '{2,  4'h0, 4'h1, 1'b1, 1'b0};
        pon_tab[2] = '{5,  4'h0, 4'h1, 1'b1, 1'b0};
        pon_tab[3] = '{6,  4'h1, 4'h3, 1'b1, 1'b0};
        pon_tab[4] = '{7,  4'h3, 4'h7, 1'b1, 1'b0};
        pon_tab[5] = '{12, 4'h3, 4'h7, 1'b1, 1'b0};
        pon_tab[6] = '{13, 4'h7, 4'hF, 1'b1, 1'b0};
        pon_tab[7] = '{14, 4'h7, 4'hF, 1'b1, 1'b0};
        pon_tab[8] = '{15, 4'hF, 4'hF, 1'b0, 1'b1};
        pon_tab[9] = '{16, 4'hF, 4'hF, 1'b0, 1'b0};

        zero_tab[0] = '{1, 4'h0, 4'h0, 1'b1, 1'b0};
        zero_tab[1] = '{2, 4'h0, 4'h1, 1'b1, 1'b0};
        zero_tab[2] = '{3, 4'h1, 4'h3, 1'b1, 1'b0};
        zero_tab[3] = '{4, 4'h3, 4'h7, 1'b1, 1'b0};
        zero_tab[4] = '{5, 4'h7, 4'hF, 1'b1, 1'b0};
        zero_tab[5] = '{6, 4'hF, 4'hF, 1'b0, 1'b1};
        zero_tab[6] = '{7, 4'hF, 4'hF, 1'b0, 1'b0};

        n_chk = 0;
        n_fail = 0;
        done_seen = 0;
        bus.sw_rst_req = 1'b0;
        bus.clk_en_req = 4'hF;
        bus.cfg_dly    = CFG_A;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state while rst_n is held low.
        repeat (3) step();
        push(cyc + 1, "rst_state", 4'h0, 4'h0, 1'b1, 1'b0);
        wait_drain(10, "rst_state");

        // Power-on sequence; a late change to d0 must not matter.
        rst_n = 1'b1;
        base = cyc;
        push_tab(base, 1'b0, 1, 16, "pon");
        repeat (2) step();
        bus.cfg_dly[7:0] = 8'd9;
        wait_drain(100, "pon");
        bus.cfg_dly = CFG_A;

        // RUN: clock enables follow requests with one cycle of latency.
        t = cyc;
        bus.clk_en_req = 4'b1010;
        push(t + 1, "run_en_a", 4'hF, 4'b1010, 1'b0, 1'b0);
        step();
        bus.clk_en_req = 4'b0101;
        push(t + 2, "run_en_b", 4'hF, 4'b0101, 1'b0, 1'b0);
        step();
        bus.clk_en_req = 4'hF;
        push(t + 3, "run_en_c", 4'hF, 4'hF, 1'b0, 1'b0);
        wait_drain(20, "run_en");

        // Software reset in RUN, with a second request during the hold that must be ignored.
        t = cyc;
        bus.sw_rst_req = 1'b1;
        push_hold(t + 1, "sw");
        step();
        bus.sw_rst_req = 1'b0;
        step();
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        push_tab(t + 3, 1'b0, 2, 16, "sw");
        wait_drain(100, "sw");

        // Abort while domain 2 is waiting, then the full sequence after the hold.
        t = cyc;
        bus.sw_rst_req = 1'b1;
        push_hold(t + 1, "abt");
        step();
        bus.sw_rst_req = 1'b0;
        base = t + 3;
        push_tab(base, 1'b0, 2, 7, "abt_pre");
        while (cyc < base + 9) step();
        bus.sw_rst_req = 1'b1;
        push_hold(base + 10, "abt");
        step();
        bus.sw_rst_req = 1'b0;
        push_tab(base + 12, 1'b0, 2, 16, "abt_post");
        wait_drain(120, "abt");

        // Asynchronous reset in the middle of a WAIT, between clock edges.
        t = cyc;
        bus.sw_rst_req = 1'b1;
        push_hold(t + 1, "arst");
        step();
        bus.sw_rst_req = 1'b0;
        base = t + 3;
        push_tab(base, 1'b0, 2, 7, "arst_pre");
        while (cyc < base + 9) step();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.dom_rst_n !== 4'h0 || bus.dom_clk_en !== 4'h0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_immediate: got rst=%b en=%b busy=%b done=%b, want rst=0000 en=0000 busy=1 done=0",
                     bus.dom_rst_n, bus.dom_clk_en, bus.busy, bus.done);
        end else begin
            $display("chk arst_immediate rst=%b en=%b busy=%b done=%b ok",
                     bus.dom_rst_n, bus.dom_clk_en, bus.busy, bus.done);
        end
        push(cyc + 1, "arst_low", 4'h0, 4'h0, 1'b1, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        base = cyc;
        push_tab(base, 1'b0, 1, 16, "arst_post");
        bus.sw_rst_req = 1'b1;
        step();
        bus.sw_rst_req = 1'b0;
        wait_drain(100, "arst");

        // All-zero delays: back-to-back releases.
        #2 rst_n = 1'b0;
        step();
        bus.cfg_dly = '0;
        step();
        rst_n = 1'b1;
        base = cyc;
        push_tab(base, 1'b1, 1, 7, "zero");
        wait_drain(50, "zero");

        // One done pulse per completed sequence, none for aborted ones.
        n_chk++;
        if (done_seen != 5) begin
            n_fail++;
            $display("FAIL done_count: got %0d pulses, want 5", done_seen);
        end else begin
            $display("chk done_count %0d ok", done_seen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
